cx_wb_merge: RTL and testbench

- Downstream stage of the custom-instruction unit.
- Captures the unit's one-cycle result pulses (valid, rd, data) into a small FIFO.
- Merges them onto the single register-file write port; the core pipeline's own writeback always has priority.
- Holds a per-register pending scoreboard and an outstanding-issue credit count, so dispatch can stall on hazards and never overflow the FIFO.

---
 rtl/cx_wb_merge_pkg.sv | 18 +
 rtl/cx_wb_merge_fifo.sv | 52 +++++
 rtl/cx_wb_merge.sv | 112 +++++++++++
 tb/tb_cx_wb_merge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cx_wb_merge_pkg.sv
// Shared types for the custom-instruction writeback merge stage.
// Register-index width, default data width and the FIFO / write-port records.
package cx_wb_merge_pkg;
  localparam int CX_XLEN = 32;
  localparam int RIDX_W  = 5;

  typedef struct packed {
    logic [RIDX_W-1:0]  rd;
    logic [CX_XLEN-1:0] data;
  } cx_entry_t;

  // Register-file write port; the core writeback stage drives the same record.
  typedef struct packed {
    logic               we;
    logic [RIDX_W-1:0]  wa;
    logic [CX_XLEN-1:0] wd;
  } rf_port_t;
endpackage

// File: rtl/cx_wb_merge_fifo.sv
// Synchronous DEPTH-entry FIFO with show-ahead head, count, full and empty.
// Handshake: push is accepted when not full or when popping in the same cycle; pop only when not empty.
module cx_wb_merge_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cx_wb_merge.sv
// Merges custom-unit results onto the register-file write port behind the core writeback,
// tracking pending destinations and outstanding-issue credits for dispatch stalls.
module cx_wb_merge
  import cx_wb_merge_pkg::*;
#(
  parameter int XLEN  = CX_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_v,
  input  logic [4:0]      issue_rd,
  input  logic            cx_v,
  input  logic [4:0]      cx_rd,
  input  logic [XLEN-1:0] cx_data,
  input  logic            core_wb_v,
  input  logic [4:0]      core_wb_rd,
  input  logic [XLEN-1:0] core_wb_data,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic [4:0]      q_rd,
  output logic            hazard,
  output logic            issue_stall,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            ovf_err
);
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(DEPTH);

  cx_entry_t   head;
  cx_entry_t   new_entry;
  logic [CW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        issue_ok;
  logic        err_now;

  rf_port_t    rf_q, rf_d;
  logic [31:0] pending_q, pending_d;
  logic [CW:0] out_q, out_d;

  // The core path always owns the port; the FIFO drains only in idle core cycles.
  assign pop       = !core_wb_v && !fifo_empty;
  assign push      = cx_v && (!fifo_full || pop);
  assign issue_ok  = issue_v && !issue_stall;
  assign new_entry = '{rd: cx_rd, data: cx_data};
  assign err_now   = (cx_v && !pop && (fifo_count == FULL_CNT)) || (issue_v && issue_stall);

  cx_wb_merge_fifo #(
    .W     ($bits(cx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (new_entry),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rf_d    = rf_q;
    rf_d.we = 1'b0;
    if (core_wb_v) begin
      rf_d = '{we: (core_wb_rd != '0), wa: core_wb_rd, wd: core_wb_data};
    end else if (pop) begin
      rf_d = '{we: (head.rd != '0), wa: head.rd, wd: head.data};
    end
  end

  // Clear before set so a same-cycle reissue of the popped register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head.rd] = 1'b0;
    if (issue_ok && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    out_d = out_q;
    if (issue_ok && !pop)                     out_d = out_q + 1'b1;
    else if (!issue_ok && pop && out_q != '0) out_d = out_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q        <= '0;
      pending_q   <= '0;
      out_q       <= '0;
      issue_stall <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      pending_q   <= pending_d;
      out_q       <= out_d;
      issue_stall <= (out_d == FULL_CNT);
      ovf_err     <= ovf_err | err_now;
    end
  end

  assign hazard = pending_q[q_rs1] | pending_q[q_rs2] | pending_q[q_rd];
  assign rf_we  = rf_q.we;
  assign rf_wa  = rf_q.wa;
  assign rf_wd  = rf_q.wd;
endmodule

// File: tb/tb_cx_wb_merge.sv
// Directed bench for cx_wb_merge: writeback merge, priority, credits, x0, wrap and reset.
module tb_cx_wb_merge;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_v;
  logic [4:0]  issue_rd;
  logic        cx_v;
  logic [4:0]  cx_rd;
  logic [31:0] cx_data;
  logic        core_wb_v;
  logic [4:0]  core_wb_rd;
  logic [31:0] core_wb_data;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        hazard, issue_stall, rf_we, ovf_err;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int vectors     = 0;
  int miscompares = 0;

  cx_wb_merge dut (
    .clk          (clk),
    .reset        (reset),
    .issue_v      (issue_v),
    .issue_rd     (issue_rd),
    .cx_v         (cx_v),
    .cx_rd        (cx_rd),
    .cx_data      (cx_data),
    .core_wb_v    (core_wb_v),
    .core_wb_rd   (core_wb_rd),
    .core_wb_data (core_wb_data),
    .q_rs1        (q_rs1),
    .q_rs2        (q_rs2),
    .q_rd         (q_rd),
    .hazard       (hazard),
    .issue_stall  (issue_stall),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the edge and are held across the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_v = 1'b0; issue_rd = '0;
    cx_v = 1'b0; cx_rd = '0; cx_data = '0;
    core_wb_v = 1'b0; core_wb_rd = '0; core_wb_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    do_reset();
    chk("rst_we", rf_we, 0);
    chk("rst_wa", rf_wa, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_stall", issue_stall, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_hazard", hazard, 0);

    // Single result to r5.
    q_rs1 = 5'd5;
    issue_v = 1'b1; issue_rd = 5'd5;
    tick();
    chk("s1_haz_issue", hazard, 1);
    chk("s1_we_issue", rf_we, 0);
    issue_v = 1'b0;
    cx_v = 1'b1; cx_rd = 5'd5; cx_data = 32'h2A;
    tick();
    chk("s1_haz_push", hazard, 1);
    chk("s1_we_push", rf_we, 0);
    cx_v = 1'b0;
    tick();
    chk("s1_we", rf_we, 1);
    chk("s1_wa", rf_wa, 5);
    chk("s1_wd", rf_wd, 32'h2A);
    chk("s1_haz_clr", hazard, 0);
    tick();
    chk("s1_we_off", rf_we, 0);
    chk("s1_wa_hold", rf_wa, 5);
    chk("s1_wd_hold", rf_wd, 32'h2A);

    // Contention: core holds the port for three cycles.
    q_rs1 = 5'd3; q_rs2 = 5'd4;
    issue_v = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    tick();
    issue_v = 1'b0;
    core_wb_v = 1'b1; core_wb_rd = 5'd7; core_wb_data = 32'h77;
    cx_v = 1'b1; cx_rd = 5'd3; cx_data = 32'h11;
    tick();
    chk("c_core1_wa", rf_wa, 7);
    chk("c_core1_wd", rf_wd, 32'h77);
    cx_rd = 5'd4; cx_data = 32'h22;
    tick();
    chk("c_core2_wa", rf_wa, 7);
    cx_v = 1'b0;
    tick();
    chk("c_core3_we", rf_we, 1);
    chk("c_core3_wa", rf_wa, 7);
    chk("c_haz_held", hazard, 1);
    core_wb_v = 1'b0;
    tick();
    chk("c_r3_we", rf_we, 1);
    chk("c_r3_wa", rf_wa, 3);
    chk("c_r3_wd", rf_wd, 32'h11);
    tick();
    chk("c_r4_wa", rf_wa, 4);
    chk("c_r4_wd", rf_wd, 32'h22);
    chk("c_haz_clr", hazard, 0);
    tick();
    chk("c_drained", rf_we, 0);

    // Credit full with core holding the port.
    q_rs1 = 5'd6; q_rs2 = '0;
    core_wb_v = 1'b1; core_wb_rd = 5'd9; core_wb_data = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      issue_v = 1'b1; issue_rd = 5'(i);
      tick();
      chk("cr_stall", issue_stall, (i == 4) ? 64'd1 : 64'd0);
    end
    issue_rd = 5'd6;
    tick();
    chk("cr_ovf", ovf_err, 1);
    chk("cr_stall_kept", issue_stall, 1);
    chk("cr_ignored", hazard, 0);
    issue_v = 1'b0;
    cx_v = 1'b1; cx_rd = 5'd1; cx_data = 32'h100;
    tick();
    chk("cr_stall_nopop", issue_stall, 1);
    cx_v = 1'b0; core_wb_v = 1'b0;
    tick();
    chk("cr_stall_drop", issue_stall, 0);
    chk("cr_pop_wa", rf_wa, 1);
    chk("cr_pop_wd", rf_wd, 32'h100);
    do_reset();
    chk("cr_rst_ovf", ovf_err, 0);

    // x0 result: no write, no hazard, credit returns.
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    issue_v = 1'b1; issue_rd = '0;
    tick();
    chk("x0_haz_issue", hazard, 0);
    issue_v = 1'b0;
    cx_v = 1'b1; cx_rd = '0; cx_data = 32'hFFFF_FFFF;
    tick();
    chk("x0_haz_push", hazard, 0);
    cx_v = 1'b0;
    tick();
    chk("x0_we", rf_we, 0);
    core_wb_v = 1'b1; core_wb_rd = '0; core_wb_data = 32'h5;
    for (int i = 1; i <= 4; i++) begin
      issue_v = 1'b1; issue_rd = 5'(i + 10);
      tick();
      chk("x0_core_we", rf_we, 0);
      chk("x0_credit", issue_stall, (i == 4) ? 64'd1 : 64'd0);
    end
    do_reset();

    // Wrap-around: ten results through the FIFO in order.
    for (int i = 0; i <= 11; i++) begin
      issue_v = (i < 10); issue_rd = 5'(i + 1);
      cx_v = (i >= 1 && i <= 10); cx_rd = 5'(i); cx_data = 32'(i * 3);
      tick();
      if (i >= 2) begin
        chk("w_we", rf_we, 1);
        chk("w_wa", rf_wa, 64'(i - 1));
        chk("w_wd", rf_wd, 64'((i - 1) * 3));
      end
      chk("w_stall", issue_stall, 0);
    end
    idle();
    tick();
    chk("w_done", rf_we, 0);
    chk("w_ovf", ovf_err, 0);

    // Reset with three results queued behind the core.
    q_rs1 = 5'd1; q_rs2 = 5'd2; q_rd = 5'd3;
    for (int i = 1; i <= 3; i++) begin
      issue_v = 1'b1; issue_rd = 5'(i);
      tick();
    end
    issue_v = 1'b0;
    core_wb_v = 1'b1; core_wb_rd = 5'd8; core_wb_data = 32'h88;
    for (int i = 1; i <= 3; i++) begin
      cx_v = 1'b1; cx_rd = 5'(i); cx_data = 32'(i + 32'h40);
      tick();
    end
    chk("rm_haz_pre", hazard, 1);
    do_reset();
    chk("rm_we", rf_we, 0);
    chk("rm_haz", hazard, 0);
    chk("rm_stall", issue_stall, 0);
    chk("rm_ovf", ovf_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm_no_write", rf_we, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
